// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and defaults for the LFSR bank sequencer.
// State encoding is 3 bits so it fits the legacy state register width.
package lfsr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CAPT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;
    localparam int unsigned CNT_W        = 16;

endpackage

// File: rtl/lfsr_word_buf.sv
// Captured-word register with valid/ready handshake; latency 1 from cap_i to valid_o.
// Holds data_o stable while ready_i is low; abort_i clears valid_o and wins over a handshake.
// Optional parity output under LFSR_BANK_CTRL_PARITY_EN.
module lfsr_word_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_i,
    input  logic        abort_i,
    input  logic [31:0] data_i,
    input  logic        ready_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        fire_o
`ifdef LFSR_BANK_CTRL_PARITY_EN
    ,
    output logic        parity_o
`endif
);

    logic [31:0] data_q;
    logic        valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (cap_i && !abort_i) begin
                data_q <= data_i;
            end
            if (abort_i) begin
                valid_q <= 1'b0;
            end else if (cap_i) begin
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef LFSR_BANK_CTRL_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (cap_i && !abort_i) begin
            parity_q <= ^data_i;
        end
    end

    assign parity_o = parity_q;
`endif

    assign data_o  = data_q;
    assign valid_o = valid_q;
    // An aborted handshake must not count as a delivered word.
    assign fire_o  = valid_q && ready_i && !abort_i;

endmodule

// File: rtl/lfsr_bank_ctrl.sv
// Sequencer for the 32-lane LFSR bank: load, shift N cycles, capture, hand off; repeat per word.
// Optional word_parity output under LFSR_BANK_CTRL_PARITY_EN.
module lfsr_bank_ctrl #(
    parameter int unsigned SHIFTS_PER_WORD = 8,
    parameter logic [31:0] DEFAULT_SEED    = lfsr_ctrl_pkg::DEFAULT_SEED,
    parameter int unsigned CNT_W           = lfsr_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed_in,
    input  logic [CNT_W-1:0] num_words,
    output logic             ld_en,
    output logic             shift_en,
    output logic [31:0]      seed,
    input  logic [31:0]      lfsr_in,
    output logic [31:0]      word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             done
`ifdef LFSR_BANK_CTRL_PARITY_EN
    ,
    output logic             word_parity
`endif
);

    import lfsr_ctrl_pkg::*;

    localparam logic [7:0] SHIFT_LAST = 8'(SHIFTS_PER_WORD - 1);

    state_e           state_q, state_d;
    logic [7:0]       shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]      seed_q, seed_d;
    logic             fire;

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        word_cnt_d  = word_cnt_q;
        seed_d      = seed_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    seed_d     = (seed_in == '0) ? DEFAULT_SEED : seed_in;
                    word_cnt_d = num_words;
                    state_d    = (num_words == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_cnt_d = '0;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_cnt_q == SHIFT_LAST) begin
                    shift_cnt_d = '0;
                    state_d     = ST_CAPT;
                end else begin
                    shift_cnt_d = shift_cnt_q + 8'd1;
                end
            end
            ST_CAPT: state_d = ST_HOLD;
            ST_HOLD: begin
                // Counting down from the latched value means the all-ones count cannot wrap.
                if (fire) begin
                    word_cnt_d = word_cnt_q - CNT_W'(1);
                    state_d    = (word_cnt_q == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            word_cnt_q  <= '0;
            seed_q      <= '0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            word_cnt_q  <= word_cnt_d;
            seed_q      <= seed_d;
        end
    end

    lfsr_word_buf u_word_buf (
        .clk      (clk),
        .rst      (rst),
        .cap_i    (state_q == ST_CAPT),
        .abort_i  (abort),
        .data_i   (lfsr_in),
        .ready_i  (word_ready),
        .data_o   (word_out),
        .valid_o  (word_valid),
        .fire_o   (fire)
`ifdef LFSR_BANK_CTRL_PARITY_EN
        ,
        .parity_o (word_parity)
`endif
    );

    assign ld_en    = (state_q == ST_LOAD);
    assign shift_en = (state_q == ST_SHIFT);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign seed     = seed_q;

endmodule

// File: tb/tb_lfsr_bank_ctrl.sv
// Bench for lfsr_bank_ctrl: drives a behavioural LFSR bank and checks words, strobes and timing.
module tb_lfsr_bank_ctrl;

    localparam int          SPW      = 4;
    localparam logic [31:0] DEF_SEED = 32'hACE1_0001;

    logic        clk, rst, start, abort, word_ready;
    logic [31:0] seed_in, seed, lfsr_in, word_out;
    logic [15:0] num_words;
    logic        ld_en, shift_en, word_valid, busy, done;
`ifdef LFSR_BANK_CTRL_PARITY_EN
    logic        word_parity;
`endif

    lfsr_bank_ctrl #(
        .SHIFTS_PER_WORD (SPW),
        .DEFAULT_SEED    (DEF_SEED),
        .CNT_W           (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .seed_in    (seed_in),
        .num_words  (num_words),
        .ld_en      (ld_en),
        .shift_en   (shift_en),
        .seed       (seed),
        .lfsr_in    (lfsr_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .done       (done)
`ifdef LFSR_BANK_CTRL_PARITY_EN
        ,
        .word_parity (word_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural LFSR bank: one step of a 32-bit Fibonacci LFSR per shift strobe.
    function automatic logic [31:0] step(input logic [31:0] b);
        return {b[30:0], b[31] ^ b[21] ^ b[1] ^ b[0]};
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] s, input int n);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = step(v);
        return v;
    endfunction

    logic [31:0] bank_q;
    always @(posedge clk or posedge rst) begin
        if (rst)           bank_q <= '0;
        else if (ld_en)    bank_q <= seed;
        else if (shift_en) bank_q <= step(bank_q);
    end
    assign lfsr_in = bank_q;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Run-level model state: the seed the run must use and what has been observed so far.
    logic [31:0] exp_seed = '0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int ld_cnt = 0, sh_cnt = 0, bursts = 0, hs_cnt = 0, done_cnt = 0, valid_seen = 0;
    logic        prev_sh = 0, prev_v = 0, prev_r = 0, prev_a = 0;
    logic [31:0] prev_w = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (ld_en || shift_en) chk("ld_shift_excl", 32'(ld_en & shift_en), 32'd0);
            if (ld_en) begin
                ld_cnt++;
                chk("seed_at_load", seed, exp_seed);
            end
            if (shift_en) begin
                sh_cnt++;
                if (!prev_sh) bursts++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (word_valid) begin
                valid_seen++;
                chk("word_out", word_out, adv(exp_seed, (hs_cnt + 1) * SPW));
                if (word_ready && !abort) hs_cnt++;
            end
            if (prev_v && !prev_r && !prev_a) begin
                chk("stall_valid", 32'(word_valid), 32'd1);
                chk("stall_word", word_out, prev_w);
                chk("stall_shift", 32'(shift_en), 32'd0);
            end
            if (start && !busy && !abort) start_cyc = cyc;
        end
        prev_sh = shift_en && !rst;
        prev_v  = word_valid && !rst;
        prev_r  = word_ready;
        prev_a  = abort;
        prev_w  = word_out;
    end

    task automatic run_start(input logic [31:0] s, input logic [15:0] n);
        exp_seed   = (s == '0) ? DEF_SEED : s;
        ld_cnt     = 0; sh_cnt = 0; bursts = 0; hs_cnt = 0;
        done_cnt   = 0; valid_seen = 0;
        seed_in    = s;
        num_words  = n;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ld"},    32'(ld_en),      32'd0);
        chk({nm, "_shift"}, 32'(shift_en),   32'd0);
        chk({nm, "_valid"}, 32'(word_valid), 32'd0);
        chk({nm, "_done"},  32'(done),       32'd0);
        chk({nm, "_busy"},  32'(busy),       32'd0);
        chk({nm, "_seed"},  seed,            32'd0);
        chk({nm, "_word"},  word_out,        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        int sh0;
        rst = 1'b1; start = 0; abort = 0; word_ready = 0; seed_in = '0; num_words = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Hand-derived LFSR steps: 1 -> 3 -> 6 -> D -> 1B.
        chk("model_step1", step(32'h1), 32'h3);
        chk("model_adv4", adv(32'h1, 4), 32'h1B);

        // Three words back-to-back: 1 LOAD + 3*(4+2) + 1 DONE = 20 cycles.
        @(posedge clk); #1;
        word_ready = 1'b1;
        run_start(32'h1, 16'd3);
        wait_idle("A", 100);
        chk("A_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("A_shift_cnt", 32'(sh_cnt), 32'd12);
        chk("A_bursts", 32'(bursts), 32'd3);
        chk("A_handshakes", 32'(hs_cnt), 32'd3);
        chk("A_done_cnt", 32'(done_cnt), 32'd1);
        chk("A_done_time", 32'(done_cyc - start_cyc), 32'd20);

        // Zero seed substitutes the default.
        run_start(32'h0, 16'd1);
        wait_idle("B", 50);
        chk("B_seed", seed, 32'hACE1_0001);
        chk("B_handshakes", 32'(hs_cnt), 32'd1);
        chk("B_done_cnt", 32'(done_cnt), 32'd1);

        // Zero words: straight to DONE.
        run_start(32'h9, 16'd0);
        wait_idle("C", 10);
        chk("C_ld_cnt", 32'(ld_cnt), 32'd0);
        chk("C_shift_cnt", 32'(sh_cnt), 32'd0);
        chk("C_valid_seen", 32'(valid_seen), 32'd0);
        chk("C_done_cnt", 32'(done_cnt), 32'd1);
        chk("C_done_time", 32'(done_cyc - start_cyc), 32'd1);

        // Consumer stall in HOLD for 10 cycles.
        word_ready = 1'b0;
        run_start(32'h1234_5678, 16'd2);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk); #2;
            if (word_valid) found = 1;
        end
        chk("D_reach_hold", 32'(found), 32'd1);
        sh0 = sh_cnt;
        repeat (9) @(posedge clk);
        #1;
        chk("D_stall_valid", 32'(word_valid), 32'd1);
        chk("D_stall_no_shift", 32'(sh_cnt), 32'(sh0));
        word_ready = 1'b1;
        wait_idle("D", 50);
        chk("D_handshakes", 32'(hs_cnt), 32'd2);
        chk("D_done_cnt", 32'(done_cnt), 32'd1);

        // Abort in the second HOLD with ready high, then restart immediately.
        run_start(32'hDEAD_BEEF, 16'd3);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk); #2;
            if (word_valid && hs_cnt == 1) found = 1;
        end
        chk("E_reach_hold2", 32'(found), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("E_busy", 32'(busy), 32'd0);
        chk("E_valid", 32'(word_valid), 32'd0);
        chk("E_handshakes", 32'(hs_cnt), 32'd1);
        chk("E_no_done", 32'(done_cnt), 32'd0);
        run_start(32'h5, 16'd1);
        chk("E_restart_ld", 32'(ld_en), 32'd1);
        wait_idle("E2", 50);
        chk("E2_handshakes", 32'(hs_cnt), 32'd1);
        chk("E2_done_cnt", 32'(done_cnt), 32'd1);

        // start and abort together in IDLE: stays idle.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("F_busy", 32'(busy), 32'd0);
        chk("F_ld", 32'(ld_en), 32'd0);

        // Asynchronous reset in the middle of SHIFT.
        run_start(32'h7, 16'd2);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); #2;
            if (shift_en) found = 1;
        end
        chk("G_reach_shift", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("G_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("G_busy_after", 32'(busy), 32'd0);
        chk("G_no_done", 32'(done_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
